fadd16_arb: RTL and testbench

FADD16_ARB -- requirements
Module: fadd16_arb

---
 rtl/fadd16_arb.sv | 198 +++++++++++++++++++
 tb/tb_fadd16_arb.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fadd16_arb.sv
// Two-requester front end that shares one fixed-latency fadd16 core, with credit-guarded per-requester response FIFOs.
// Latency: issue in the request-handshake cycle; response visible CORE_LAT+1 cycles after the handshake.
// Backpressure: a requester is stalled (req_ready_o low) while its credit (in flight + queued) equals RSP_DEPTH.
// Build option: define FADD16_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module fadd16_arb #(
  parameter int CORE_LAT  = 2,
  parameter int RSP_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  req_valid_i,
  output logic [1:0]  req_ready_o,
  input  logic [31:0] req_opa_i,
  input  logic [31:0] req_opb_i,
  input  logic [5:0]  req_rm_i,
  output logic        core_valid_o,
  output logic [15:0] core_opa_o,
  output logic [15:0] core_opb_o,
  output logic [2:0]  core_rm_o,
  input  logic [15:0] core_res_i,
  input  logic [4:0]  core_fflags_i,
  output logic [1:0]  rsp_valid_o,
  input  logic [1:0]  rsp_ready_i,
  output logic [31:0] rsp_res_o,
  output logic [9:0]  rsp_fflags_o
);

  localparam int AW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic [4:0]  fflags;
    logic [15:0] res;
  } rsp_t;

  logic [1:0]                elig;
  logic [1:0]                grant;
  logic [1:0]                push;
  logic [1:0]                pop;
  logic [1:0][CW-1:0]        credit_q, credit_d;
  logic [1:0][CW-1:0]        cnt_q, cnt_d;
  logic [1:0][AW-1:0]        wptr_q, wptr_d;
  logic [1:0][AW-1:0]        rptr_q, rptr_d;
  logic [CORE_LAT-1:0]       tag_vld_q, tag_vld_d;
  logic [CORE_LAT-1:0]       tag_id_q, tag_id_d;
  rsp_t [1:0][RSP_DEPTH-1:0] mem_q, mem_d;

`ifndef FADD16_ARB_FIXED_PRIO_EN
  logic rr_q, rr_d;
`endif

  // Arbitration: a requester may issue only while it still owns a free response slot.
  always_comb begin
    elig  = '0;
    grant = '0;
    for (int n = 0; n < 2; n++) begin
      elig[n] = !rst && req_valid_i[n] && (credit_q[n] < CW'(RSP_DEPTH));
    end
`ifdef FADD16_ARB_FIXED_PRIO_EN
    if (elig[0]) begin
      grant = 2'b01;
    end else if (elig[1]) begin
      grant = 2'b10;
    end
`else
    if (elig == 2'b11) begin
      grant = rr_q ? 2'b10 : 2'b01;
    end else begin
      grant = elig;
    end
`endif
  end

`ifndef FADD16_ARB_FIXED_PRIO_EN
  // Preference flips to the other requester after every grant and holds otherwise.
  always_comb begin
    rr_d = rr_q;
    if (|grant) begin
      rr_d = grant[0];
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  // Issue to the core: ready mirrors the grant, operands are zero when idle.
  always_comb begin
    req_ready_o  = grant;
    core_valid_o = |grant;
    core_opa_o   = '0;
    core_opb_o   = '0;
    core_rm_o    = '0;
    if (grant[1]) begin
      core_opa_o = req_opa_i[31:16];
      core_opb_o = req_opb_i[31:16];
      core_rm_o  = req_rm_i[5:3];
    end else if (grant[0]) begin
      core_opa_o = req_opa_i[15:0];
      core_opb_o = req_opb_i[15:0];
      core_rm_o  = req_rm_i[2:0];
    end
  end

  // Response heads: valid whenever a FIFO holds data, payload zero when empty.
  always_comb begin
    rsp_valid_o  = '0;
    rsp_res_o    = '0;
    rsp_fflags_o = '0;
    for (int n = 0; n < 2; n++) begin
      if (!rst && (cnt_q[n] != '0)) begin
        rsp_valid_o[n]         = 1'b1;
        rsp_res_o[16*n +: 16]  = mem_q[n][rptr_q[n]].res;
        rsp_fflags_o[5*n +: 5] = mem_q[n][rptr_q[n]].fflags;
      end
    end
  end

  assign pop = rsp_valid_o & rsp_ready_i;

  // Tag pipe tracks which requester owns each core slot; credits and FIFOs follow push/grant/pop.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d     = '0;
    tag_vld_d[0] = |grant;
    tag_id_d[0]  = grant[1];
    for (int i = 1; i < CORE_LAT; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end

    push     = '0;
    credit_d = credit_q;
    cnt_d    = cnt_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    mem_d    = mem_q;
    for (int n = 0; n < 2; n++) begin
      push[n] = tag_vld_q[CORE_LAT-1] && (tag_id_q[CORE_LAT-1] == 1'(n));

      case ({grant[n], pop[n]})
        2'b10:   credit_d[n] = credit_q[n] + CW'(1);
        2'b01:   credit_d[n] = credit_q[n] - CW'(1);
        default: credit_d[n] = credit_q[n];
      endcase

      case ({push[n], pop[n]})
        2'b10:   cnt_d[n] = cnt_q[n] + CW'(1);
        2'b01:   cnt_d[n] = cnt_q[n] - CW'(1);
        default: cnt_d[n] = cnt_q[n];
      endcase

      if (push[n]) begin
        mem_d[n][wptr_q[n]] = '{fflags: core_fflags_i, res: core_res_i};
        wptr_d[n]           = wptr_q[n] + AW'(1);
      end
      if (pop[n]) begin
        rptr_d[n] = rptr_q[n] + AW'(1);
      end
    end
  end

  // Control state: reset drops in-flight tags so their results are never queued.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_vld_q <= '0;
      tag_id_q  <= '0;
      credit_q  <= '0;
      cnt_q     <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
    end else begin
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
      credit_q  <= credit_d;
      cnt_q     <= cnt_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
    end
  end

  // FIFO storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  for (genvar g = 0; g < 2; g++) begin : g_chk
    a_no_push_full: assert property (@(posedge clk) disable iff (rst)
      push[g] |-> (cnt_q[g] < CW'(RSP_DEPTH)));
  end

endmodule

// File: tb/tb_fadd16_arb.sv
module tb_fadd16_arb;
  localparam int CORE_LAT  = 2;
  localparam int RSP_DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [31:0] req_opa, req_opb;
  logic [5:0]  req_rm;
  logic        core_valid;
  logic [15:0] core_opa, core_opb;
  logic [2:0]  core_rm;
  logic [15:0] core_res;
  logic [4:0]  core_fflags;
  logic [1:0]  rsp_valid;
  logic [1:0]  rsp_ready;
  logic [31:0] rsp_res;
  logic [9:0]  rsp_fflags;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fadd16_arb #(.CORE_LAT(CORE_LAT), .RSP_DEPTH(RSP_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opa_i(req_opa), .req_opb_i(req_opb), .req_rm_i(req_rm),
    .core_valid_o(core_valid), .core_opa_o(core_opa), .core_opb_o(core_opb), .core_rm_o(core_rm),
    .core_res_i(core_res), .core_fflags_i(core_fflags),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_res_o(rsp_res), .rsp_fflags_o(rsp_fflags)
  );

  // Stand-in core: x+x for normal x is exact doubling; anything else gets a hash.
  function automatic logic [20:0] fake_core(logic [15:0] a, logic [15:0] b, logic [2:0] rm);
    if (a == b && a[14:10] != 5'd0 && a[14:10] < 5'd30) return {5'd0, a + 16'h0400};
    return {{b[1:0], rm} ^ a[4:0], a ^ {b[7:0], b[15:8]} ^ {13'd0, rm}};
  endfunction

  logic [20:0] stub_d [CORE_LAT];
  always @(posedge clk) begin
    stub_d[0] <= fake_core(core_opa, core_opb, core_rm);
    for (int i = 1; i < CORE_LAT; i++) stub_d[i] <= stub_d[i-1];
  end
  assign core_res    = stub_d[CORE_LAT-1][15:0];
  assign core_fflags = stub_d[CORE_LAT-1][20:16];

  // Reference model: per-requester queue of expected responses with their due cycle.
  typedef struct {
    int          due;
    logic [15:0] res;
    logic [4:0]  ff;
  } exp_t;
  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   pref = 0;

  function automatic int qsize(int n);
    return (n == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic exp_t qfront(int n);
    return (n == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  function automatic logic exp_rsp_vld(int n);
    if (rst || qsize(n) == 0) return 1'b0;
    return qfront(n).due <= cyc;
  endfunction

  function automatic logic [1:0] exp_grant(logic [1:0] v);
    logic [1:0] e;
    if (rst) return 2'b00;
    e[0] = v[0] && (exp_q0.size() < RSP_DEPTH);
    e[1] = v[1] && (exp_q1.size() < RSP_DEPTH);
`ifdef FADD16_ARB_FIXED_PRIO_EN
    if (e[0]) return 2'b01;
    if (e[1]) return 2'b10;
    return 2'b00;
`else
    if (e == 2'b11) return (pref == 0) ? 2'b01 : 2'b10;
    return e;
`endif
  endfunction

  task automatic model_commit();
    logic [1:0]  g;
    logic [20:0] r;
    exp_t        e;
    g = exp_grant(req_valid);
    if (exp_rsp_vld(0) && rsp_ready[0]) void'(exp_q0.pop_front());
    if (exp_rsp_vld(1) && rsp_ready[1]) void'(exp_q1.pop_front());
    for (int n = 0; n < 2; n++) begin
      if (g[n]) begin
        r     = fake_core(req_opa[16*n +: 16], req_opb[16*n +: 16], req_rm[3*n +: 3]);
        e.due = cyc + CORE_LAT + 1;
        e.res = r[15:0];
        e.ff  = r[20:16];
        if (n == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      end
    end
    if (g != 2'b00) pref = g[0] ? 1 : 0;
  endtask

  task automatic cycle_end();
    if (rst) begin
      exp_q0.delete();
      exp_q1.delete();
      pref = 0;
    end else begin
      model_commit();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ops();
    req_opa = $urandom;
    req_opb = $urandom;
    req_rm  = 6'($urandom);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    cycle_end();
    cycle_end();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 2'b11; rsp_ready = 2'b11; rand_ops();
    for (int i = 0; i < 4; i++) begin
      if (i == 2) begin rst = 1'b0; req_valid = 2'b00; end
      @(negedge clk);
      n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready i=%0d: got %b want 00", i, req_ready); end
      n_cmp++; if (core_valid !== 1'b0) begin n_err++; $display("FAIL reset_core_valid i=%0d: got %b want 0", i, core_valid); end
      n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid i=%0d: got %b want 00", i, rsp_valid); end
      cycle_end();
    end
  endtask

  task automatic test_single_add();
    do_reset();
    req_valid = 2'b01; req_opa = 32'h0000_3C00; req_opb = 32'h0000_3C00; req_rm = 6'd0;
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL add_ready: got %b want 01", req_ready); end
    n_cmp++; if (core_valid !== 1'b1) begin n_err++; $display("FAIL add_core_valid: got %b want 1", core_valid); end
    n_cmp++; if ({core_opa, core_opb, core_rm} !== {16'h3C00, 16'h3C00, 3'd0})
      begin n_err++; $display("FAIL add_core_ops: got %h %h %h want 3c00 3c00 0", core_opa, core_opb, core_rm); end
    cycle_end();
    req_valid = 2'b00;
    for (int k = 1; k <= CORE_LAT; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL add_early_rsp k=%0d: got %b want 00", k, rsp_valid); end
      cycle_end();
    end
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL add_rsp_valid: got %b want 01", rsp_valid); end
    n_cmp++; if (rsp_res[15:0] !== 16'h4000) begin n_err++; $display("FAIL add_rsp_res: got %h want 4000", rsp_res[15:0]); end
    n_cmp++; if (rsp_fflags[4:0] !== 5'd0) begin n_err++; $display("FAIL add_rsp_flags: got %h want 00", rsp_fflags[4:0]); end
    rsp_ready = 2'b01;
    cycle_end();
    rsp_ready = 2'b00;
    @(negedge clk);
    n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL add_after_pop: got %b want 00", rsp_valid); end
  endtask

  task automatic test_contention();
    logic [1:0] want;
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b11;
    for (int i = 0; i < 8; i++) begin
      rand_ops();
`ifdef FADD16_ARB_FIXED_PRIO_EN
      want = 2'b01;
`else
      want = (i % 2 == 0) ? 2'b01 : 2'b10;
`endif
      @(negedge clk);
      n_cmp++; if (req_ready !== want) begin n_err++; $display("FAIL cont_grant i=%0d: got %b want %b", i, req_ready, want); end
      n_cmp++; if (core_opa !== (want[1] ? req_opa[31:16] : req_opa[15:0]))
        begin n_err++; $display("FAIL cont_opa i=%0d: got %h", i, core_opa); end
      cycle_end();
    end
  endtask

  task automatic test_backpressure();
    int g0 = 0;
    do_reset();
    req_valid = 2'b11; rsp_ready = 2'b10;
    for (int i = 0; i < 16; i++) begin
      rand_ops();
      @(negedge clk);
      n_cmp++; if (req_ready !== exp_grant(req_valid))
        begin n_err++; $display("FAIL bp_ready i=%0d: got %b want %b", i, req_ready, exp_grant(req_valid)); end
      if (req_ready[0]) g0++;
      cycle_end();
    end
    n_cmp++; if (g0 !== RSP_DEPTH) begin n_err++; $display("FAIL bp_grants0: got %0d want %0d", g0, RSP_DEPTH); end
    // Drain a single entry from the full FIFO: requester 0 regains exactly one slot.
    rsp_ready = 2'b11; rand_ops();
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL drain_stalled: got %b want 10", req_ready); end
    n_cmp++; if (rsp_valid[0] !== 1'b1 || rsp_res[15:0] !== qfront(0).res)
      begin n_err++; $display("FAIL drain_head: got %b/%h want 1/%h", rsp_valid[0], rsp_res[15:0], qfront(0).res); end
    cycle_end();
    rsp_ready = 2'b10; rand_ops();
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL drain_regrant: got %b want 01", req_ready); end
    cycle_end();
    rand_ops();
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL drain_refull: got %b want 10", req_ready); end
    cycle_end();
  endtask

  task automatic test_simultaneous();
    int both = 0;
    do_reset();
    req_valid = 2'b01; rsp_ready = 2'b01;
    for (int i = 0; i < 24; i++) begin
      rand_ops();
      @(negedge clk);
      n_cmp++; if (req_ready !== exp_grant(req_valid))
        begin n_err++; $display("FAIL sim_ready i=%0d: got %b want %b", i, req_ready, exp_grant(req_valid)); end
      n_cmp++; if (rsp_valid[0] !== exp_rsp_vld(0))
        begin n_err++; $display("FAIL sim_rsp_valid i=%0d: got %b want %b", i, rsp_valid[0], exp_rsp_vld(0)); end
      if (exp_rsp_vld(0)) begin
        n_cmp++; if ({rsp_fflags[4:0], rsp_res[15:0]} !== {qfront(0).ff, qfront(0).res})
          begin n_err++; $display("FAIL sim_order i=%0d: got %h/%h want %h/%h", i, rsp_fflags[4:0], rsp_res[15:0], qfront(0).ff, qfront(0).res); end
        if (req_ready[0]) both++;
      end
      cycle_end();
    end
    n_cmp++; if (both < 16) begin n_err++; $display("FAIL sim_grant_and_pop: got %0d want >=16", both); end
  endtask

  task automatic test_reset_mid();
    int g0 = 0;
    do_reset();
    req_valid = 2'b01; rsp_ready = 2'b11;
    rand_ops(); cycle_end();
    rand_ops(); cycle_end();
    req_valid = 2'b00; rst = 1'b1;
    cycle_end();
    rst = 1'b0;
    for (int k = 0; k < CORE_LAT + 3; k++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL mid_rsp k=%0d: got %b want 00", k, rsp_valid); end
      cycle_end();
    end
    rsp_ready = 2'b00; req_valid = 2'b11; rand_ops();
    @(negedge clk);
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL mid_first_grant: got %b want 01", req_ready); end
    if (req_ready[0]) g0++;
    cycle_end();
    req_valid = 2'b01;
    for (int k = 0; k < RSP_DEPTH + 2; k++) begin
      rand_ops();
      @(negedge clk);
      if (req_ready[0]) g0++;
      cycle_end();
    end
    n_cmp++; if (g0 !== RSP_DEPTH) begin n_err++; $display("FAIL mid_credit: got %0d grants want %0d", g0, RSP_DEPTH); end
  endtask

  task automatic test_random();
    logic [1:0] eg;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      req_valid = 2'($urandom);
      rsp_ready = 2'($urandom);
      rand_ops();
      eg = exp_grant(req_valid);
      @(negedge clk);
      n_cmp++; if (req_ready !== eg) begin n_err++; $display("FAIL rnd_ready i=%0d: got %b want %b", i, req_ready, eg); end
      n_cmp++; if ({core_valid, core_opa, core_rm} !== {|eg,
                   eg[1] ? req_opa[31:16] : (eg[0] ? req_opa[15:0] : 16'h0),
                   eg[1] ? req_rm[5:3]    : (eg[0] ? req_rm[2:0]    : 3'h0)})
        begin n_err++; $display("FAIL rnd_issue i=%0d: got %b/%h/%h", i, core_valid, core_opa, core_rm); end
      for (int n = 0; n < 2; n++) begin
        n_cmp++; if (rsp_valid[n] !== exp_rsp_vld(n))
          begin n_err++; $display("FAIL rnd_rsp_valid i=%0d n=%0d: got %b want %b", i, n, rsp_valid[n], exp_rsp_vld(n)); end
        if (exp_rsp_vld(n)) begin
          n_cmp++; if ({rsp_fflags[5*n +: 5], rsp_res[16*n +: 16]} !== {qfront(n).ff, qfront(n).res})
            begin n_err++; $display("FAIL rnd_rsp_data i=%0d n=%0d: got %h/%h want %h/%h", i, n,
                                    rsp_fflags[5*n +: 5], rsp_res[16*n +: 16], qfront(n).ff, qfront(n).res); end
        end else begin
          n_cmp++; if ({rsp_fflags[5*n +: 5], rsp_res[16*n +: 16]} !== 21'h0)
            begin n_err++; $display("FAIL rnd_rsp_idle i=%0d n=%0d: got %h/%h want 0", i, n, rsp_fflags[5*n +: 5], rsp_res[16*n +: 16]); end
        end
      end
      cycle_end();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req_valid = 2'b00; rsp_ready = 2'b00;
    req_opa = '0; req_opb = '0; req_rm = '0;
    test_reset();
    test_single_add();
    test_contention();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
